// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline stage family: default payload width,
// occupancy codes and an occupancy helper.
package pipe_pkg;

   localparam int unsigned CPU_WIDTH = 32;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
      logic [1:0] occ;
      case ({main_v, skid_v})
         2'b00:        occ = OCC_EMPTY;
         2'b10, 2'b01: occ = OCC_ONE;
         2'b11:        occ = OCC_FULL;
         default:      occ = OCC_EMPTY;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream side
// (in_*) and downstream side (out_*). The stage itself uses the slave modport.
interface pipe_stage_reg_if
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = CPU_WIDTH
);
   logic             in_valid_i;
   logic [WIDTH-1:0] in_data_i;
   logic             in_ready_o;
   logic             out_valid_o;
   logic [WIDTH-1:0] out_data_o;
   logic             out_ready_i;

   modport master (
      output in_valid_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o
   );

   modport slave (
      input  in_valid_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o
   );
endinterface

// File: rtl/pipe_skid_buf.sv
// Second entry of the stage: captures a payload that arrives while the main
// entry is full and not draining, and hands it back when the main entry drains.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH   = CPU_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);
   logic             skid_v_r;
   logic [WIDTH-1:0] skid_d_r;

   // Skid entry register; data is only rewritten when a payload is pushed.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         skid_v_r <= 1'b0;
         skid_d_r <= RST_VAL;
      end else if (flush_i) begin
         skid_v_r <= 1'b0;
         skid_d_r <= RST_VAL;
      end else if (push_i) begin
         skid_v_r <= 1'b1;
         skid_d_r <= data_i;
      end else if (pop_i) begin
         skid_v_r <= 1'b0;
      end else begin
         skid_v_r <= skid_v_r;
      end
   end

   assign valid_o = skid_v_r;
   assign data_o  = skid_d_r;
endmodule

// File: rtl/pipe_stage_reg.sv
// Single pipeline register stage with stall, flush and valid/ready handshake.
// Define PIPE_STAGE_SKID_EN to add a skid entry and break out_ready -> in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH   = CPU_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   stall_i,
   pipe_stage_reg_if.slave        bus,
   output logic [1:0]             occ_o
);
   logic             main_v_r;
   logic [WIDTH-1:0] main_d_r;
   logic             main_v_nx_s;
   logic [WIDTH-1:0] main_d_nx_s;
   logic             skid_v_s;
   logic [WIDTH-1:0] skid_d_s;
   logic             in_ready_s;
   logic             out_valid_s;
   logic             accept_s;
   logic             drain_s;

   assign out_valid_s = main_v_r & ~stall_i;
   assign drain_s     = out_valid_s & bus.out_ready_i;
   assign accept_s    = bus.in_valid_i & in_ready_s;

`ifdef PIPE_STAGE_SKID_EN
   logic skid_push_s;
   logic skid_pop_s;

   // A payload goes to skid only when main stays occupied this edge.
   assign skid_push_s = accept_s & main_v_r & ~drain_s;
   assign skid_pop_s  = skid_v_s & drain_s;
   assign in_ready_s  = ~stall_i & ~skid_v_s;

   pipe_skid_buf #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
   ) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (skid_push_s),
      .pop_i   (skid_pop_s),
      .data_i  (bus.in_data_i),
      .valid_o (skid_v_s),
      .data_o  (skid_d_s)
   );
`else
   assign skid_v_s   = 1'b0;
   assign skid_d_s   = RST_VAL;
   assign in_ready_s = ~stall_i & (~main_v_r | bus.out_ready_i);
`endif

   // Next main entry: refill from skid, load a new payload, or empty on drain.
   always_comb begin
      main_v_nx_s = main_v_r;
      main_d_nx_s = main_d_r;
      if (skid_v_s && drain_s) begin
         main_d_nx_s = skid_d_s;
      end else if (accept_s && (!main_v_r || drain_s)) begin
         main_v_nx_s = 1'b1;
         main_d_nx_s = bus.in_data_i;
      end else if (drain_s) begin
         main_v_nx_s = 1'b0;
      end else begin
         main_v_nx_s = main_v_r;
      end
   end

   // Main entry register; reset dominates flush, flush dominates stall.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         main_v_r <= 1'b0;
         main_d_r <= RST_VAL;
      end else if (flush_i) begin
         main_v_r <= 1'b0;
         main_d_r <= RST_VAL;
      end else begin
         main_v_r <= main_v_nx_s;
         main_d_r <= main_d_nx_s;
      end
   end

   assign bus.in_ready_o  = in_ready_s;
   assign bus.out_valid_o = out_valid_s;
   assign bus.out_data_o  = main_d_r;
   assign occ_o           = occ_count(main_v_r, skid_v_s);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a queue-based model of a stage with
// capacity 1 (or 2 with PIPE_STAGE_SKID_EN), directed scenarios plus random traffic.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int unsigned W = 32;
`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush = 1'b0;
   logic       stall = 1'b0;
   logic [1:0] occ;

   pipe_stage_reg_if #(.WIDTH(W)) bus ();

   pipe_stage_reg #(.WIDTH(W)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .stall_i (stall),
      .bus     (bus),
      .occ_o   (occ)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   logic [W-1:0] exp_q[$];
   logic        ready_exp = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a FIFO of accepted payloads, emptied by reset or flush.
   initial forever begin
      @(posedge clk);
      if (!rst || flush) exp_q.delete();
      else if (bus.in_valid_i && ready_exp) exp_q.push_back(bus.in_data_i);
   end

   // Monitor: compare handshake outputs against the model, pop on every delivery.
   initial forever begin
      int sz;
      logic exp_valid;
      @(negedge clk);
      sz = exp_q.size();
      if (CAP == 2) ready_exp = !stall && (sz < 2);
      else          ready_exp = !stall && (sz == 0 || bus.out_ready_i);
      exp_valid = (sz > 0) && !stall;
      check("in_ready", {31'd0, bus.in_ready_o}, {31'd0, ready_exp});
      check("out_valid", {31'd0, bus.out_valid_o}, {31'd0, exp_valid});
      check("occ", {30'd0, occ}, sz);
      if (occ > CAP) check("occ_bound", {30'd0, occ}, CAP);
      if (bus.out_valid_o) begin
         if (sz == 0) check("unexpected_output", bus.out_data_o, 32'hDEAD_BEEF);
         else begin
            check("out_data", bus.out_data_o, exp_q[0]);
            if (bus.out_ready_i) void'(exp_q.pop_front());
         end
      end
   end

   // Drive one cycle's inputs just after the edge, return at the following negedge.
   task automatic cyc(input logic r, input logic v, input logic [W-1:0] d,
                      input logic ordy, input logic st, input logic fl);
      @(posedge clk);
      #1;
      rst = r; bus.in_valid_i = v; bus.in_data_i = d;
      bus.out_ready_i = ordy; stall = st; flush = fl;
      @(negedge clk);
   endtask

   initial begin
      bus.in_valid_i = 1'b0; bus.in_data_i = 32'd0; bus.out_ready_i = 1'b0;

      // Reset for two cycles, then release.
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      check("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
      check("rst_occ", {30'd0, occ}, 32'd0);
      check("rst_out_data", bus.out_data_o, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);

      // Streaming 1..4 back to back.
      cyc(1'b1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
      for (int i = 2; i <= 5; i++) begin
         cyc(1'b1, (i <= 4), i, 1'b1, 1'b0, 1'b0);
         check("stream_valid", {31'd0, bus.out_valid_o}, 32'd1);
         check("stream_data", bus.out_data_o, i - 1);
      end
      cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      check("stream_end", {31'd0, bus.out_valid_o}, 32'd0);

      // Backpressure.
      cyc(1'b1, 1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
      check("bp_in_ready_1", {31'd0, bus.in_ready_o}, 32'd1);
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      check("bp_occ_full", {30'd0, occ}, 32'd2);
      check("bp_in_ready_0", {31'd0, bus.in_ready_o}, 32'd0);
      cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      check("bp_first", bus.out_data_o, 32'hA);
      check("bp_occ2", {30'd0, occ}, 32'd2);
      cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      check("bp_second", bus.out_data_o, 32'hB);
      check("bp_occ1", {30'd0, occ}, 32'd1);
      cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      check("bp_occ0", {30'd0, occ}, 32'd0);
`else
      check("bp_in_ready_0", {31'd0, bus.in_ready_o}, 32'd0);
      check("bp_occ1", {30'd0, occ}, 32'd1);
      check("bp_hold", bus.out_data_o, 32'hA);
      cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      check("bp_first", bus.out_data_o, 32'hA);
      cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      check("bp_occ0", {30'd0, occ}, 32'd0);
`endif

      // Stall with a held payload.
      cyc(1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
         check("stall_valid", {31'd0, bus.out_valid_o}, 32'd0);
         check("stall_occ", {30'd0, occ}, 32'd1);
         check("stall_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
      end
      cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      check("stall_release", bus.out_data_o, 32'h55);
      cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      check("stall_once", {31'd0, bus.out_valid_o}, 32'd0);

      // Flush a full stage while stalled and offered new input.
      cyc(1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
      if (CAP == 2) cyc(1'b1, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1);
      check("flush_pre_occ", {30'd0, occ}, CAP);
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      check("flush_occ", {30'd0, occ}, 32'd0);
      check("flush_data", bus.out_data_o, 32'd0);

      // Random traffic with occasional stall, flush and reset.
      for (int i = 0; i < 10000; i++) begin
         cyc(($urandom_range(0, 511) != 0), $urandom_range(0, 1), $urandom,
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 63) == 0));
      end
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      check("drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
